// File: rtl/mul12_pkg.sv
// Shared constants and state encoding for the nibble-serial 12x12 multiplier.
package mul12_pkg;

    localparam int NIBBLE_W = 4;
    localparam int NIBBLES  = 3;
    localparam int OP_W     = NIBBLE_W * NIBBLES;
    localparam int PROD_W   = 24;
    localparam int STEPS    = NIBBLES * NIBBLES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul12_seq_ctrl_if.sv
// Operand and product handshake bundle between a producer/consumer and mul12_seq_ctrl.
interface mul12_seq_ctrl_if;
    import mul12_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] p;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );

endinterface

// File: rtl/mul12_seq_ctrl_mult4.sv
// Existing 4x4 unsigned partial-product unit, shared by all nine nibble steps.
module MULTIPLIER4BIT (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = {4'b0, a} * {4'b0, b};

endmodule

// File: rtl/mul12_seq_ctrl.sv
// Sequential 12x12 unsigned multiplier: one 4x4 multiplier stepped over nine
// nibble pairs, accumulating shifted partial products into a 24-bit result.
module mul12_seq_ctrl
    import mul12_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    mul12_seq_ctrl_if.slave bus
);

    localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);

    state_t              state;
    logic [OP_W-1:0]     a_r;
    logic [OP_W-1:0]     b_r;
    logic [1:0]          i_cnt;
    logic [1:0]          j_cnt;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   p_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                busy_r;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [7:0]          pp;
    logic [2:0]          pos_sum;
    logic [4:0]          shift_amt;
    logic [PROD_W-1:0]   term;
    logic [PROD_W-1:0]   acc_next;
    logic                zero_op;

    // Nibble selection reads only the registered operands, so live inputs never leak in.
    always_comb begin
        nib_a = a_r[3:0];
        nib_b = b_r[3:0];
        case (i_cnt)
            2'd1:    nib_a = a_r[7:4];
            2'd2:    nib_a = a_r[11:8];
            default: nib_a = a_r[3:0];
        endcase
        case (j_cnt)
            2'd1:    nib_b = b_r[7:4];
            2'd2:    nib_b = b_r[11:8];
            default: nib_b = b_r[3:0];
        endcase
    end

    MULTIPLIER4BIT u_mult4 (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    assign pos_sum   = {1'b0, i_cnt} + {1'b0, j_cnt};
    assign shift_amt = {pos_sum, 2'b00};
    assign term      = {16'b0, pp} << shift_amt;
    assign acc_next  = acc + term;
    assign zero_op   = (bus.a == '0) || (bus.b == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            i_cnt       <= '0;
            j_cnt       <= '0;
            acc         <= '0;
            p_r         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        acc        <= '0;
                        i_cnt      <= '0;
                        j_cnt      <= '0;
                        in_ready_r <= 1'b0;
                        if (ZERO_SKIP && zero_op) begin
                            p_r         <= '0;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            busy_r <= 1'b1;
                            state  <= MUL;
                        end
                    end
                end
                // j walks B's nibbles fastest; the last pair publishes the sum directly.
                MUL: begin
                    acc <= acc_next;
                    if (i_cnt == LAST_IDX && j_cnt == LAST_IDX) begin
                        p_r         <= acc_next;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= DONE;
                    end else if (j_cnt == LAST_IDX) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + 2'd1;
                    end else begin
                        j_cnt <= j_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.p         = p_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mul12_seq_ctrl.sv
// Directed bench for mul12_seq_ctrl: one instance without and one with zero skip.
module tb_mul12_seq_ctrl;
    import mul12_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   lat;
    int   busyCnt;

    mul12_seq_ctrl_if bus0 ();
    mul12_seq_ctrl_if bus1 ();

    mul12_seq_ctrl #(.ZERO_SKIP(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mul12_seq_ctrl #(.ZERO_SKIP(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents operands to dut0 for one acceptance edge, then drops in_valid.
    task automatic applyStimulus(input logic [11:0] av, input logic [11:0] bv);
        bus0.a        = av;
        bus0.b        = bv;
        bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until dut0 raises out_valid, with a budget.
    task automatic waitOut();
        lat     = 0;
        busyCnt = 0;
        while (!bus0.out_valid && lat < 30) begin
            if (bus0.busy) busyCnt++;
            step();
            lat++;
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus0.in_valid = 1'b0;
        bus0.a        = '0;
        bus0.b        = '0;
        bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.a        = '0;
        bus1.b        = '0;
        bus1.out_ready = 1'b1;

        step();
        step();
        checkOutput("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        checkOutput("rst_busy", 32'(bus0.busy), 32'd0);
        checkOutput("rst_p", 32'(bus0.p), 32'd0);
        checkOutput("rst_zs_in_ready", 32'(bus1.in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        bus0.out_ready = 1'b1;
        applyStimulus(12'hFFF, 12'hFFF);
        checkOutput("max_busy_after_e0", 32'(bus0.busy), 32'd1);
        checkOutput("max_in_ready_after_e0", 32'(bus0.in_ready), 32'd0);
        waitOut();
        checkOutput("max_latency", 32'(lat), 32'd9);
        checkOutput("max_busy_cycles", 32'(busyCnt), 32'd9);
        checkOutput("max_p", 32'(bus0.p), 32'h00FFE001);
        checkOutput("max_busy_done", 32'(bus0.busy), 32'd0);
        step();
        checkOutput("max_valid_pulse", 32'(bus0.out_valid), 32'd0);
        checkOutput("max_back_idle", 32'(bus0.in_ready), 32'd1);

        bus0.out_ready = 1'b0;
        applyStimulus(12'h123, 12'h456);
        waitOut();
        checkOutput("hold_latency", 32'(lat), 32'd9);
        for (int k = 0; k < 5; k++) begin
            bus0.a        = 12'h007;
            bus0.b        = 12'h007;
            bus0.in_valid = k[0];
            step();
            checkOutput("hold_p", 32'(bus0.p), 32'h0004EDC2);
            checkOutput("hold_out_valid", 32'(bus0.out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(bus0.in_ready), 32'd0);
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        step();
        checkOutput("hold_release_valid", 32'(bus0.out_valid), 32'd0);
        checkOutput("hold_release_ready", 32'(bus0.in_ready), 32'd1);
        checkOutput("hold_p_retained", 32'(bus0.p), 32'h0004EDC2);
        checkOutput("hold_no_accept", 32'(bus0.busy), 32'd0);

        applyStimulus(12'h00A, 12'h00B);
        bus0.a = 12'hFFF;
        bus0.b = 12'hFFF;
        waitOut();
        checkOutput("opchg_latency", 32'(lat), 32'd9);
        checkOutput("opchg_p", 32'(bus0.p), 32'h0000006E);
        step();

        applyStimulus(12'h000, 12'h800);
        waitOut();
        checkOutput("zero_noskip_latency", 32'(lat), 32'd9);
        checkOutput("zero_noskip_p", 32'(bus0.p), 32'd0);
        step();

        // Give the zero-skip instance a nonzero result first so P=0 is meaningful.
        bus1.a        = 12'h005;
        bus1.b        = 12'h007;
        bus1.in_valid = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 30) begin
            step();
            lat++;
        end
        checkOutput("zs_nonzero_latency", 32'(lat), 32'd9);
        checkOutput("zs_nonzero_p", 32'(bus1.p), 32'h00000023);
        step();
        bus1.a        = 12'h000;
        bus1.b        = 12'h800;
        bus1.in_valid = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        checkOutput("zs_out_valid", 32'(bus1.out_valid), 32'd1);
        checkOutput("zs_busy", 32'(bus1.busy), 32'd0);
        checkOutput("zs_p", 32'(bus1.p), 32'd0);
        step();
        checkOutput("zs_back_idle", 32'(bus1.in_ready), 32'd1);
        checkOutput("zs_busy_idle", 32'(bus1.busy), 32'd0);

        applyStimulus(12'h321, 12'h654);
        for (int k = 0; k < 4; k++) step();
        checkOutput("abort_busy_before", 32'(bus0.busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("abort_in_ready", 32'(bus0.in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(bus0.out_valid), 32'd0);
        checkOutput("abort_busy", 32'(bus0.busy), 32'd0);
        checkOutput("abort_p", 32'(bus0.p), 32'd0);

        applyStimulus(12'h002, 12'h003);
        waitOut();
        checkOutput("fresh_latency", 32'(lat), 32'd9);
        checkOutput("fresh_p", 32'(bus0.p), 32'd6);
        step();
        checkOutput("fresh_release", 32'(bus0.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
